// File: rtl/pll_ctrl_pkg.sv
// Purpose: shared types and helpers for the rPLL reconfiguration controller.
//   pll_state_e   : sequencing states of the controller
//   DIV_W         : width of one rPLL divider field
//   mode_width()  : width of a mode index for a given preset count (min 1)
//   cnt_width()   : width of a counter that must hold 0..max_val (min 1)
//   gowin_div_enc : static-style divider value -> Gowin dynamic-select encoding
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABLE,
        READY,
        FAIL
    } pll_state_e;

    localparam int unsigned DIV_W = 6;

    function automatic int unsigned mode_width(input int unsigned num_modes);
        return (num_modes <= 1) ? 1 : $clog2(num_modes);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Dynamic divider inputs take 63 - sel, i.e. the bitwise inverse.
    function automatic logic [DIV_W-1:0] gowin_div_enc(input logic [DIV_W-1:0] sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d_i : asynchronous input
//   q_o : synchronized output (two destination-clock edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Purpose: run-time controller for the Gowin rPLL dynamic dividers. Selects one
// of NUM_MODES divider presets and sequences PLL reset, lock acquisition, lock
// debounce and timeout, re-acquiring lock automatically after a lock loss.
// Ports:
//   refclk       : controller clock (PLL reference clock)
//   reset        : asynchronous active-high reset
//   mode_sel     : requested preset index
//   mode_req     : single-cycle request strobe
//   req_err      : one-cycle pulse for an out-of-range request
//   active_mode  : preset currently applied
//   busy         : reset/lock sequence in progress
//   ready        : PLL locked and stable on active_mode
//   fail         : lock timeout, sticky until the next accepted request
//   pll_lock_i   : rPLL lock output (asynchronous)
//   pll_reset_o  : rPLL reset
//   fdiv_o/idiv_o/odsel_o : rPLL dynamic divider inputs
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned              NUM_MODES           = 2,
    parameter int unsigned              DEFAULT_MODE        = 0,
    parameter logic [DIV_W*NUM_MODES-1:0] FBDIV_TABLE       = {6'd18, 6'd18},
    parameter logic [DIV_W*NUM_MODES-1:0] IDIV_TABLE        = {6'd5, 6'd5},
    parameter logic [DIV_W*NUM_MODES-1:0] ODIV_TABLE        = {6'd8, 6'd8},
    parameter int unsigned              RESET_CYCLES        = 16,
    parameter int unsigned              LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned              LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                               refclk,
    input  logic                               reset,
    input  logic [mode_width(NUM_MODES)-1:0]   mode_sel,
    input  logic                               mode_req,
    output logic                               req_err,
    output logic [mode_width(NUM_MODES)-1:0]   active_mode,
    output logic                               busy,
    output logic                               ready,
    output logic                               fail,
    input  logic                               pll_lock_i,
    output logic                               pll_reset_o,
    output logic [DIV_W-1:0]                   fdiv_o,
    output logic [DIV_W-1:0]                   idiv_o,
    output logic [DIV_W-1:0]                   odsel_o
);

    localparam int unsigned MW    = mode_width(NUM_MODES);
    localparam int unsigned RST_W = cnt_width(RESET_CYCLES);
    localparam int unsigned STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);

    // Terminal counts: exit RESET_HOLD after RESET_CYCLES+1 edges in the state,
    // the last stable/timeout cycle is the one where the counter holds N-1.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

    localparam logic [MW-1:0]    MODE_RST  = MW'(DEFAULT_MODE);
    localparam logic [DIV_W-1:0] FDIV_RST  = gowin_div_enc(FBDIV_TABLE[DIV_W*DEFAULT_MODE +: DIV_W]);
    localparam logic [DIV_W-1:0] IDIV_RST  = gowin_div_enc(IDIV_TABLE[DIV_W*DEFAULT_MODE +: DIV_W]);
    localparam logic [DIV_W-1:0] ODSEL_RST = ODIV_TABLE[DIV_W*DEFAULT_MODE +: DIV_W];

    pll_state_e         state_q, state_d;
    logic [MW-1:0]      active_mode_q, active_mode_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [DIV_W-1:0]   fdiv_q, fdiv_d;
    logic [DIV_W-1:0]   idiv_q, idiv_d;
    logic [DIV_W-1:0]   odsel_q, odsel_d;
    logic               pll_reset_q, pll_reset_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               req_err_q, req_err_d;
    logic               lock_c;
    logic               sel_valid_c;
    logic               enter_hold;
    int unsigned        tbl_base;

    // Lock synchronizer into the refclk domain.
    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (reset),
        .d_i (pll_lock_i),
        .q_o (lock_c)
    );

    assign sel_valid_c = (32'(mode_sel) < NUM_MODES);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d       = state_q;
        active_mode_d = active_mode_q;
        rst_cnt_d     = rst_cnt_q;
        stb_cnt_d     = stb_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        fdiv_d        = fdiv_q;
        idiv_d        = idiv_q;
        odsel_d       = odsel_q;
        req_err_d     = 1'b0;
        enter_hold    = 1'b0;
        tbl_base      = 0;

        if (mode_req && sel_valid_c) begin
            // Accepted request aborts whatever is running, even for the same mode.
            active_mode_d = mode_sel;
            state_d       = RESET_HOLD;
            rst_cnt_d     = '0;
            stb_cnt_d     = '0;
            tmo_cnt_d     = '0;
            enter_hold    = 1'b1;
        end else begin
            req_err_d = mode_req;
            unique case (state_q)
                RESET_HOLD: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = WAIT_LOCK;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_c) begin
                        state_d   = STABLE;
                        stb_cnt_d = '0;
                    end else if (tmo_cnt_q >= TMO_LAST) begin
                        state_d = FAIL;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                STABLE: begin
                    // Timeout budget is shared across glitches, so it is not cleared here.
                    if (!lock_c) begin
                        state_d = WAIT_LOCK;
                    end else if (stb_cnt_q == STB_LAST) begin
                        state_d = READY;
                    end else begin
                        stb_cnt_d = stb_cnt_q + STB_W'(1);
                    end
                end
                READY: begin
                    if (!lock_c) begin
                        state_d    = RESET_HOLD;
                        rst_cnt_d  = '0;
                        stb_cnt_d  = '0;
                        tmo_cnt_d  = '0;
                        enter_hold = 1'b1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d    = RESET_HOLD;
                    rst_cnt_d  = '0;
                    enter_hold = 1'b1;
                end
            endcase
        end

        // Dividers only move on entry to RESET_HOLD, while the PLL is held in reset.
        if (enter_hold) begin
            tbl_base = DIV_W * 32'(active_mode_d);
            fdiv_d   = gowin_div_enc(FBDIV_TABLE[tbl_base +: DIV_W]);
            idiv_d   = gowin_div_enc(IDIV_TABLE[tbl_base +: DIV_W]);
            odsel_d  = ODIV_TABLE[tbl_base +: DIV_W];
        end

        pll_reset_d = (state_d == RESET_HOLD) || (state_d == FAIL);
        busy_d      = (state_d == RESET_HOLD) || (state_d == WAIT_LOCK) || (state_d == STABLE);
        ready_d     = (state_d == READY);
        fail_d      = (state_d == FAIL);
    end

    // State, counters and output registers.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q       <= RESET_HOLD;
            active_mode_q <= MODE_RST;
            rst_cnt_q     <= '0;
            stb_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            fdiv_q        <= FDIV_RST;
            idiv_q        <= IDIV_RST;
            odsel_q       <= ODSEL_RST;
            pll_reset_q   <= 1'b1;
            busy_q        <= 1'b1;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            req_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_mode_q <= active_mode_d;
            rst_cnt_q     <= rst_cnt_d;
            stb_cnt_q     <= stb_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            fdiv_q        <= fdiv_d;
            idiv_q        <= idiv_d;
            odsel_q       <= odsel_d;
            pll_reset_q   <= pll_reset_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
            req_err_q     <= req_err_d;
        end
    end

    assign req_err     = req_err_q;
    assign active_mode = active_mode_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign pll_reset_o = pll_reset_q;
    assign fdiv_o      = fdiv_q;
    assign idiv_o      = idiv_q;
    assign odsel_o     = odsel_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl. Cycle k is the interval just after the
// k-th rising edge following reset release; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_pll_reconfig_ctrl;

    logic       refclk = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] mode_sel = 2'd0;
    logic       mode_req = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       req_err;
    logic [1:0] active_mode;
    logic       busy;
    logic       ready;
    logic       fail;
    logic       pll_reset_o;
    logic [5:0] fdiv_o;
    logic [5:0] idiv_o;
    logic [5:0] odsel_o;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int at       = 0;

    // Mode 0: fb 18, in 5, od 8; mode 1: fb 24, in 4, od 4; mode 2: fb 30, in 5, od 8.
    pll_reconfig_ctrl #(
        .NUM_MODES           (3),
        .DEFAULT_MODE        (0),
        .FBDIV_TABLE         ({6'd30, 6'd24, 6'd18}),
        .IDIV_TABLE          ({6'd5, 6'd4, 6'd5}),
        .ODIV_TABLE          ({6'd8, 6'd4, 6'd8}),
        .RESET_CYCLES        (16),
        .LOCK_STABLE_CYCLES  (256),
        .LOCK_TIMEOUT_CYCLES (100)
    ) dut (
        .refclk      (refclk),
        .reset       (reset),
        .mode_sel    (mode_sel),
        .mode_req    (mode_req),
        .req_err     (req_err),
        .active_mode (active_mode),
        .busy        (busy),
        .ready       (ready),
        .fail        (fail),
        .pll_lock_i  (pll_lock_i),
        .pll_reset_o (pll_reset_o),
        .fdiv_o      (fdiv_o),
        .idiv_o      (idiv_o),
        .odsel_o     (odsel_o)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until ready is high or the cycle limit is hit; -1 on expiry.
    task automatic wait_ready(input int limit, output int when);
        when = -1;
        while (ready !== 1'b1 && cyc < limit) tick();
        if (ready === 1'b1) when = cyc;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge refclk);
        #1;
        chk("rst_pll_reset", 32'(pll_reset_o), 32'd1);
        chk("rst_busy",      32'(busy),        32'd1);
        chk("rst_ready",     32'(ready),       32'd0);
        chk("rst_fail",      32'(fail),        32'd0);
        chk("rst_req_err",   32'(req_err),     32'd0);
        chk("rst_mode",      32'(active_mode), 32'd0);
        chk("rst_fdiv",      32'(fdiv_o),      32'd45);
        chk("rst_idiv",      32'(idiv_o),      32'd58);
        chk("rst_odsel",     32'(odsel_o),     32'd8);
        reset = 1'b0;
        cyc   = 0;

        // Power-up: reset held cycles 0..16, lock from cycle 20, ready at 23+256.
        run_to(16);
        chk("pu_reset_c16", 32'(pll_reset_o), 32'd1);
        tick();
        chk("pu_reset_c17", 32'(pll_reset_o), 32'd0);
        chk("pu_busy_c17",  32'(busy),        32'd1);
        run_to(20);
        pll_lock_i = 1'b1;
        wait_ready(400, at);
        chk("pu_ready_cycle", 32'(at), 32'd279);
        chk("pu_busy_ready",  32'(busy), 32'd0);

        // Switch to mode 1; PLL drops lock while reset, relocks as reset falls.
        run_to(285);
        mode_sel   = 2'd1;
        mode_req   = 1'b1;
        pll_lock_i = 1'b0;
        tick();
        mode_req = 1'b0;
        n = cyc;
        chk("sw_busy",      32'(busy),        32'd1);
        chk("sw_ready",     32'(ready),       32'd0);
        chk("sw_pll_reset", 32'(pll_reset_o), 32'd1);
        chk("sw_mode",      32'(active_mode), 32'd1);
        chk("sw_fdiv",      32'(fdiv_o),      32'd39);
        chk("sw_idiv",      32'(idiv_o),      32'd59);
        chk("sw_odsel",     32'(odsel_o),     32'd4);
        run_to(n + 16);
        chk("sw_reset_n16", 32'(pll_reset_o), 32'd1);
        tick();
        chk("sw_reset_n17", 32'(pll_reset_o), 32'd0);
        pll_lock_i = 1'b1;
        wait_ready(n + 400, at);
        chk("sw_ready_cycle", 32'(at - n), 32'd276);

        // Back to mode 0 with a 10-cycle lock glitch while in STABLE.
        mode_sel   = 2'd0;
        mode_req   = 1'b1;
        pll_lock_i = 1'b0;
        tick();
        mode_req = 1'b0;
        n = cyc;
        chk("gl_mode", 32'(active_mode), 32'd0);
        chk("gl_fdiv", 32'(fdiv_o),      32'd45);
        run_to(n + 17);
        pll_lock_i = 1'b1;
        run_to(n + 50);
        pll_lock_i = 1'b0;
        run_to(n + 55);
        chk("gl_busy",      32'(busy),        32'd1);
        chk("gl_pll_reset", 32'(pll_reset_o), 32'd0);
        run_to(n + 60);
        pll_lock_i = 1'b1;
        wait_ready(n + 500, at);
        chk("gl_ready_cycle", 32'(at - n), 32'd319);

        // Lock lost in READY: retry on same mode, then time out (lock never returns).
        n = cyc;
        pll_lock_i = 1'b0;
        run_to(n + 2);
        chk("ll_ready_n2", 32'(ready), 32'd1);
        tick();
        chk("ll_ready_n3",     32'(ready),       32'd0);
        chk("ll_pll_reset_n3", 32'(pll_reset_o), 32'd1);
        chk("ll_busy_n3",      32'(busy),        32'd1);
        chk("ll_mode_n3",      32'(active_mode), 32'd0);
        run_to(n + 119);
        chk("to_fail_n119", 32'(fail), 32'd0);
        tick();
        chk("to_fail_n120",  32'(fail),        32'd1);
        chk("to_pll_reset",  32'(pll_reset_o), 32'd1);
        chk("to_busy",       32'(busy),        32'd0);
        chk("to_ready",      32'(ready),       32'd0);
        run_to(n + 125);
        chk("to_fail_sticky", 32'(fail), 32'd1);

        // Out-of-range request: one-cycle req_err, nothing else moves.
        mode_sel = 2'd3;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        chk("oor_req_err",   32'(req_err),     32'd1);
        chk("oor_fail",      32'(fail),        32'd1);
        chk("oor_mode",      32'(active_mode), 32'd0);
        chk("oor_pll_reset", 32'(pll_reset_o), 32'd1);
        tick();
        chk("oor_req_err_off", 32'(req_err), 32'd0);
        chk("oor_fail_still",  32'(fail),    32'd1);

        // Valid request clears fail and loads mode 2.
        mode_sel = 2'd2;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        n = cyc;
        chk("rq_fail",  32'(fail),        32'd0);
        chk("rq_busy",  32'(busy),        32'd1);
        chk("rq_mode",  32'(active_mode), 32'd2);
        chk("rq_fdiv",  32'(fdiv_o),      32'd33);
        chk("rq_idiv",  32'(idiv_o),      32'd58);
        chk("rq_odsel", 32'(odsel_o),     32'd8);
        chk("rq_req_err", 32'(req_err),   32'd0);

        // Async reset in WAIT_LOCK, between clock edges.
        run_to(n + 20);
        chk("ar_wait_lock", 32'(pll_reset_o), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_pll_reset", 32'(pll_reset_o), 32'd1);
        chk("ar_busy",      32'(busy),        32'd1);
        chk("ar_ready",     32'(ready),       32'd0);
        chk("ar_fail",      32'(fail),        32'd0);
        chk("ar_mode",      32'(active_mode), 32'd0);
        chk("ar_fdiv",      32'(fdiv_o),      32'd45);
        chk("ar_odsel",     32'(odsel_o),     32'd8);
        @(posedge refclk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        // Lock already high: sync at cycle 2, WAIT_LOCK at 17, STABLE at 18.
        pll_lock_i = 1'b1;
        wait_ready(400, at);
        chk("ar_ready_cycle", 32'(at), 32'd274);
        chk("ar_ready_mode",  32'(active_mode), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
